// File: rtl/mul_dot_accumulator_pkg.sv
// rtl/mul_dot_accumulator_pkg.sv - shared defaults, state encoding and length helper for the dot-product accumulator
package mul_dot_accumulator_pkg;

    localparam int DEF_IN_W  = 32;
    localparam int DEF_LEN_W = 8;
    localparam int DEF_ACC_W = 40;
    localparam int DEF_DEPTH = 2;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    // A programmed length of 0 stands for the largest vector, 2^len_w products.
    function automatic int unsigned eff_len(input int unsigned len_val, input int unsigned len_w);
        return (len_val == 0) ? (32'd1 << len_w) : len_val;
    endfunction

endpackage

// File: rtl/mul_dot_result_fifo.sv
// rtl/mul_dot_result_fifo.sv - small synchronous result FIFO with simultaneous push/pop when full
module mul_dot_result_fifo #(
    parameter int DEPTH = 2,
    parameter int ACC_W = 40
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic [ACC_W-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [ACC_W-1:0] head_data
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [ACC_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic [ACC_W-1:0] last_q;
    logic             do_pop;
    logic             do_push;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_IDX) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_push = push && (!full || do_pop);

    // When empty the output keeps showing the most recently popped entry.
    assign head_data = empty ? last_q : mem[rd_ptr];

    // Storage array; pointers are reset, contents need not be.
    always_ff @(posedge clk) begin
        if (do_push && !clear) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer, occupancy and last-popped bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            last_q <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            last_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
                last_q <= mem[rd_ptr];
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mul_dot_accumulator.sv
// rtl/mul_dot_accumulator.sv - sums a programmable number of multiplier products into buffered dot-product results
module mul_dot_accumulator
    import mul_dot_accumulator_pkg::*;
#(
    parameter int IN_W  = DEF_IN_W,
    parameter int LEN_W = DEF_LEN_W,
    parameter int ACC_W = DEF_ACC_W,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  in_data,
    input  logic [LEN_W-1:0] len,
    input  logic             clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic             busy,
    output logic             drop_sticky
);

    localparam logic [LEN_W:0] CNT_ONE = (LEN_W + 1)'(1);

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [LEN_W:0]   cnt;
    logic [LEN_W:0]   len_q;
    logic [LEN_W:0]   len_eff;
    logic [LEN_W:0]   cnt_inc;
    logic [ACC_W-1:0] sum;
    logic [ACC_W-1:0] result;
    logic             complete;
    logic             push;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [ACC_W-1:0] fifo_head;

    // Decide whether this cycle's product finishes a vector and what the finished sum is.
    always_comb begin
        len_eff  = (LEN_W + 1)'(eff_len(32'(len), LEN_W));
        cnt_inc  = cnt + CNT_ONE;
        sum      = acc + ACC_W'(in_data);
        complete = 1'b0;
        result   = '0;
        if (in_valid) begin
            case (state)
                IDLE: begin
                    complete = (len_eff == CNT_ONE);
                    result   = ACC_W'(in_data);
                end
                ACCUM: begin
                    complete = (cnt_inc == len_q);
                    result   = sum;
                end
                default: begin
                    complete = 1'b0;
                    result   = '0;
                end
            endcase
        end
    end

    // Clear wins over both the incoming product and the consumer handshake.
    assign push = complete && !clear;
    assign pop  = out_valid && out_ready && !clear;

    // Accumulation state machine; length is latched only on a vector's first product.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            len_q <= '0;
        end else if (clear) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            len_q <= '0;
        end else if (in_valid) begin
            case (state)
                IDLE: begin
                    len_q <= len_eff;
                    acc   <= ACC_W'(in_data);
                    cnt   <= CNT_ONE;
                    state <= (len_eff == CNT_ONE) ? IDLE : ACCUM;
                end
                ACCUM: begin
                    acc <= sum;
                    cnt <= cnt_inc;
                    if (cnt_inc == len_q) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Remember that a finished result found no room; only reset or clear forget it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_sticky <= 1'b0;
        end else if (clear) begin
            drop_sticky <= 1'b0;
        end else if (push && fifo_full && !pop) begin
            drop_sticky <= 1'b1;
        end
    end

    mul_dot_result_fifo #(
        .DEPTH (DEPTH),
        .ACC_W (ACC_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .push      (push),
        .push_data (result),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head_data (fifo_head)
    );

    assign out_valid = !fifo_empty;
    assign out_data  = fifo_head;
    assign busy      = (state == ACCUM);

endmodule

// File: doc/mul_dot_accumulator.md
Name: mul_dot_accumulator

Overview:
- Downstream consumer of the 16-bit pipelined multiplier. Takes the product stream (mul_en_out / mul_out) and sums a programmable number of consecutive products into one dot-product result.
- Completed results go into a 2-entry output FIFO with a valid/ready handshake.
- The multiplier cannot be back-pressured, so results that arrive when the FIFO is full are dropped and flagged.

Parameters:
- IN_W, 32, product width; matches the multiplier output.
- LEN_W, 8, width of the vector-length field.
- ACC_W, 40, accumulator and result width. Must satisfy ACC_W >= IN_W + LEN_W, so the sum never wraps.
- DEPTH, 2, output FIFO depth in entries.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  product strobe; connects to the multiplier's mul_en_out
- in_data  in  IN_W  product; connects to mul_out
- len  in  LEN_W  products per vector; 0 means 2^LEN_W (256)
- clear  in  1  synchronous soft clear
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  consumer accepts the head entry
- out_data  out  ACC_W  dot-product result at the FIFO head
- busy  out  1  a vector is partially accumulated
- drop_sticky  out  1  at least one completed result was lost since the last clear or reset

Behaviour:
- Reset (rst high, asynchronous):
  - state = IDLE; acc, cnt and len_q are 0; FIFO is empty.
  - out_valid = 0, out_data = 0, busy = 0, drop_sticky = 0.
  - A partially accumulated vector is discarded.
- States are IDLE and ACCUM. Registers:
  - acc (ACC_W bits)
  - cnt (LEN_W+1 bits)
  - len_q (LEN_W+1 bits; a len of 0 is stored as 2^LEN_W)
- IDLE with in_valid:
  - Sample len into len_q. len is sampled only here; changes mid-vector are ignored.
  - acc = zero-extended in_data, cnt = 1.
  - If the effective length is 1, the vector completes this cycle and the state stays IDLE. Otherwise go to ACCUM.
- ACCUM with in_valid:
  - acc += in_data, cnt += 1.
  - If cnt+1 == len_q, the vector completes and the state returns to IDLE.
- in_valid low in any state: hold all registers. Gaps between products are allowed.
- Completion:
  - The full sum (acc + in_data, or in_data alone for length 1) is pushed into the FIFO on the same clock edge.
  - out_valid rises the cycle after the last product's in_valid; latency is 1 cycle.
  - acc is not needed again until the next first product.
- Arithmetic: unsigned, zero-extended. The parameter constraint guarantees no overflow. Worst case is 256 × (2^32-1) = 0xFF_FFFF_FF00.
- FIFO:
  - out_valid = !empty; out_data = head entry. When empty, out_data holds its last value (0 after reset).
  - Pop on out_valid && out_ready.
  - Push and pop in the same cycle are both performed, including when the FIFO is full. The pop frees the slot and the push succeeds.
  - Push while full with no pop in that cycle: the result is dropped, drop_sticky is set, and the FIFO is unchanged.
  - Pop while empty: no effect.
- clear:
  - Same effect as reset, but synchronous. FIFO contents and drop_sticky are cleared.
  - Takes priority over in_valid and out_ready in the same cycle. The product arriving that cycle is discarded and no pop occurs.
- busy = (state == ACCUM).

Decomposition:
- Shared package holds:
  - the IN_W / LEN_W / ACC_W defaults
  - the state enum (IDLE, ACCUM)
  - the effective-length helper function (0 maps to 2^LEN_W)
- One natural sub-module: mul_dot_result_fifo. It is a synchronous FIFO with parameters DEPTH and ACC_W, push/pop/full/empty signals, and async active-high reset plus sync clear.

Test Plan:
- len=4, out_ready=1, products 1,2,3,4 on consecutive cycles -> one cycle after the 4th, out_valid=1 for exactly 1 cycle with out_data=10; busy high from the 2nd to the 4th cycle.
- len=1, out_ready=0, products 5,6,7 -> FIFO holds 5,6; drop_sticky=1. Then out_ready=1 -> out_data 5 then 6, then out_valid=0.
- len=0 (256), every product 0xFFFF_FFFF -> single result 0xFF_FFFF_FF00; no intermediate out_valid.
- len=3, products 2 _ _ 3 _ 4 with bubbles, and len changed to 1 after the first product -> result 9 (len change ignored).
- len=4, two products then clear=1 together with in_valid -> busy=0 and FIFO empty. Then products 1,1,1,1 -> result 4. Repeat with rst pulsed mid-vector -> same outcome, all outputs 0 while rst is high.
- FIFO full (2 entries) with out_ready=1 on the cycle a new vector completes -> pop and push both occur, no drop, drop_sticky stays 0, order preserved.
